// File: rtl/hsv_core_decode_stage.sv
// hsv_core_decode_stage: RV32 decoder feeding a DEPTH-entry output FIFO; define HSV_DECODE_STATS_EN for accept/illegal counters
module hsv_core_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_core,
  input  logic            rst_core,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
`ifdef HSV_DECODE_STATS_EN
  output logic [31:0]     cnt_decoded,
  output logic [31:0]     cnt_illegal,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_we,
  output logic            out_illegal
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [6:0] OP = 7'h33, OP_IMM = 7'h13, LOAD = 7'h03, JALR = 7'h67, SYSTEM = 7'h73;
  localparam logic [6:0] MISC_MEM = 7'h0F, STORE = 7'h23, BRANCH = 7'h63, LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F;
  logic [31:0]     r_insn [DEPTH];
  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [XLEN-1:0] r_imm  [DEPTH];
  logic [2:0]      r_fmt  [DEPTH];
  logic            r_ill  [DEPTH];
  logic            r_we   [DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_occ;
  logic [6:0]      w_op;
  logic [2:0]      w_fmt;
  logic            w_ill, w_we, w_acc, w_pop;
  logic signed [31:0] w_imm32;
  logic [31:0]     w_hd;
  assign in_ready  = !rst_core && !flush && (r_occ < FULL);
  assign out_valid = !rst_core && (r_occ != '0);
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Decode the incoming instruction; unknown opcodes fall to R with a zero immediate
  always_comb begin
    w_op    = in_insn[6:0];
    w_fmt   = w_op == OP ? 3'd0 :
              (w_op == OP_IMM || w_op == LOAD || w_op == JALR || w_op == SYSTEM || w_op == MISC_MEM) ? 3'd1 :
              w_op == STORE ? 3'd2 :
              w_op == BRANCH ? 3'd3 :
              (w_op == LUI || w_op == AUIPC) ? 3'd4 :
              w_op == JAL ? 3'd5 : 3'd0;
    w_ill   = in_insn[1:0] != 2'b11 || (w_fmt == 3'd0 && w_op != OP);
    w_imm32 = w_fmt == 3'd1 ? {{20{in_insn[31]}}, in_insn[31:20]} :
              w_fmt == 3'd2 ? {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]} :
              w_fmt == 3'd3 ? {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0} :
              w_fmt == 3'd4 ? {in_insn[31:12], 12'b0} :
              w_fmt == 3'd5 ? {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0} :
              32'sd0;
    w_we    = !w_ill && w_fmt != 3'd2 && w_fmt != 3'd3 && in_insn[11:7] != 5'd0;
  end
  // Capture decoded entry at the write pointer; payload is masked by out_valid so needs no reset
  always_ff @(posedge clk_core) begin
    if (w_acc) begin
      r_insn[r_wp] <= in_insn;
      r_pc[r_wp]   <= in_pc;
      r_imm[r_wp]  <= XLEN'(w_imm32);
      r_fmt[r_wp]  <= w_fmt;
      r_ill[r_wp]  <= w_ill;
      r_we[r_wp]   <= w_we;
    end
  end
  // Pointers and occupancy; reset and flush both empty the buffer and win over accept/pop
  always_ff @(posedge clk_core) begin
    if (rst_core || flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_acc) r_wp <= r_wp == LAST ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == LAST ? '0 : r_rp + 1'b1;
      r_occ <= (w_acc && !w_pop) ? r_occ + 1'b1 : (!w_acc && w_pop) ? r_occ - 1'b1 : r_occ;
    end
  end
`ifdef HSV_DECODE_STATS_EN
  // Count at accept time; only reset clears, flush leaves the totals alone
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      cnt_decoded <= '0;
      cnt_illegal <= '0;
    end else if (w_acc) begin
      cnt_decoded <= cnt_decoded + 32'd1;
      if (w_ill) cnt_illegal <= cnt_illegal + 32'd1;
    end
  end
`endif
  // Present the head entry, all zero whenever nothing is valid
  always_comb begin
    w_hd        = r_insn[r_rp];
    out_pc      = out_valid ? r_pc[r_rp] : '0;
    out_opcode  = out_valid ? w_hd[6:0] : '0;
    out_funct3  = out_valid ? w_hd[14:12] : '0;
    out_funct7  = out_valid ? w_hd[31:25] : '0;
    out_rd      = out_valid ? w_hd[11:7] : '0;
    out_rs1     = out_valid ? w_hd[19:15] : '0;
    out_rs2     = out_valid ? w_hd[24:20] : '0;
    out_imm     = out_valid ? r_imm[r_rp] : '0;
    out_fmt     = out_valid ? r_fmt[r_rp] : '0;
    out_rd_we   = out_valid && r_we[r_rp];
    out_illegal = out_valid && r_ill[r_rp];
  end
endmodule

// File: doc/hsv_core_decode_stage.md
HSV_CORE_DECODE_STAGE -- requirements
Module: hsv_core_decode_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL provide parameter DEPTH, default 2, output buffer entries; legal range 1..8.
REQ-003 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-004 SHALL have port clk_core  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_core  input  1  synchronous active-high reset.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1, in_insn  input  32, in_pc  input  XLEN, which carry the fetched instruction with its handshake.
REQ-007 SHALL have port flush  input  1  synchronous discard of all buffered and incoming instructions.
REQ-008 SHALL have ports out_valid  output  1, out_ready  input  1, which form the decoded-entry handshake.
REQ-009 SHALL have decoded fields out_pc (XLEN), out_opcode (7), out_funct3 (3), out_funct7 (7), out_rd, out_rs1 and out_rs2 (5 each), out_imm (XLEN), out_fmt (3: R=0, I=1, S=2, B=3, U=4, J=5), out_rd_we (1) and out_illegal (1).
REQ-010 SHALL, when compiled with HSV_DECODE_STATS_EN, add outputs cnt_decoded  output  32 and cnt_illegal  output  32.

Function
REQ-011 SHALL accept an instruction in a cycle where in_valid and in_ready are both 1 ("accept").
REQ-012 SHALL drive in_ready = (occupancy < DEPTH) and not flush; a full buffer SHALL NOT accept, even when an entry pops in the same cycle.
REQ-013 SHALL present an entry accepted in cycle N on the outputs no earlier than cycle N+1, which is the minimum latency.
REQ-014 SHALL pop the head entry in a cycle where out_valid and out_ready are both 1, and SHALL keep outputs stable while out_valid=1 and out_ready=0.
REQ-015 SHALL, on a simultaneous accept and pop when not full, leave occupancy unchanged and preserve FIFO order.
REQ-016 SHALL wrap the read and write pointers modulo DEPTH.
REQ-017 SHALL classify the format by in_insn[6:0]:
- OP gives R.
- OP_IMM, LOAD, JALR, SYSTEM and MISC_MEM give I.
- STORE gives S.
- BRANCH gives B.
- LUI and AUIPC give U.
- JAL gives J.
REQ-018 SHALL set out_illegal=1 when in_insn[1:0]!=2'b11 or the opcode is outside REQ-017; in that case out_fmt=R and out_imm=0.
REQ-019 SHALL build the immediate from the standard RV32 I/S/B/U/J bit layouts, sign-extended from insn[31] to XLEN; for XLEN=64 the U immediate SHALL be sign-extended from bit 31.
REQ-020 SHALL drive out_imm=0 for format R.
REQ-021 SHALL pass the raw bit-fields rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12] and funct7=[31:25] through unchanged.
REQ-022 SHALL drive out_rd_we=1 only when all of the following hold: format is R, I, U or J; rd!=0; out_illegal=0.
REQ-023 SHALL, on flush, zero occupancy and pointers at the next edge and drop any instruction presented that cycle; out_valid=0 the following cycle.
REQ-024 SHALL give flush priority over accept and pop in the same cycle.

Reset
REQ-025 SHALL, while rst_core=1, clear occupancy and pointers and drive out_valid=0 and in_ready=0.
REQ-026 SHALL zero all data outputs and both counters on reset.
REQ-027 SHALL, on reset asserted mid-transfer, discard all buffered entries; in_ready=1 in the first cycle after deassertion.

Configuration
REQ-028 SHALL, with macro HSV_DECODE_STATS_EN defined, increment cnt_decoded on every accept, and also increment cnt_illegal when that instruction is illegal.
REQ-029 SHALL count at accept time; counters wrap modulo 2^32, flush SHALL NOT clear them, and only reset clears them.
REQ-030 SHALL, without HSV_DECODE_STATS_EN, omit both counter ports and their logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: XLEN=32, accept 0xFFF00093 (addi x1,x0,-1) -> next cycle out_fmt=1, out_rd=1, out_imm=0xFFFFFFFF, out_rd_we=1, out_illegal=0.
REQ-032 SHALL cover: accept 0xFE000EE3 (beq x0,x0,-4) -> out_fmt=3, out_imm=0xFFFFFFFC, out_rd_we=0.
REQ-033 SHALL cover: XLEN=64, accept 0x80000037 (lui x0,0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4, out_rd_we=0.
REQ-034 SHALL cover: DEPTH=2, out_ready=0, three back-to-back valid instructions -> only the first two accepted, in_ready=0 while full; out_ready=1 -> entries pop in order and the third is accepted once a slot frees.
REQ-035 SHALL cover: two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, dropped instruction never emerges, and with stats enabled cnt_decoded is unchanged by the flush.
REQ-036 SHALL cover: with HSV_DECODE_STATS_EN, accept 0x00000000 and 0x00000013 -> cnt_decoded=2, cnt_illegal=1.
